// File: rtl/morse_pkg.sv
// morse_pkg
//   Shared types and defaults for the Morse game round controller.
//   - state_t : round controller FSM state, 3-bit encoding
//   - bcd_t   : one BCD digit (0..9)
//   - *_DEF   : default LIVES / WIN_SCORE / WARN_DIGIT parameter values
//   - MAX_BCD : largest legal BCD digit
package morse_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_ARM  = 3'd2,
    ST_RUN  = 3'd3,
    ST_HIT  = 3'd4,
    ST_MISS = 3'd5,
    ST_WIN  = 3'd6,
    ST_LOSE = 3'd7
  } state_t;

  typedef logic [3:0] bcd_t;

  localparam int   LIVES_DEF      = 3;
  localparam int   WIN_SCORE_DEF  = 9;
  localparam int   WARN_DIGIT_DEF = 2;
  localparam bcd_t MAX_BCD        = 4'd9;

endpackage

// File: rtl/bcd_sat_counter.sv
// bcd_sat_counter
//   Single BCD digit up counter that stops at 9 instead of wrapping.
//   Ports:
//     i_clk   : clock, rising edge
//     i_rst_n : asynchronous active-low reset (count -> 0)
//     i_clr   : synchronous clear, has priority over i_inc
//     i_inc   : increment by one (no effect once the count is 9)
//     o_q     : current count
module bcd_sat_counter
  import morse_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_clr,
  input  logic       i_inc,
  output logic [3:0] o_q
);

  bcd_t r_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_q <= '0;
    end else if (i_clr) begin
      r_q <= '0;
    end else if (i_inc && (r_q < MAX_BCD)) begin
      r_q <= r_q + 4'd1;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/morse_round_ctrl.sv
// morse_round_ctrl
//   Round controller for the Morse game. Drives the round timer (enable,
//   reconfig), watches its TimeOut/ones outputs, scores guesses, tracks lives
//   and declares win or lose.
//   Ports:
//     clk           : clock, rising edge
//     rst           : asynchronous active-low reset
//     start         : pulse, starts a game from IDLE / WIN / LOSE
//     guess_valid   : pulse, a guess completed this cycle
//     guess_correct : qualifies guess_valid
//     TimeOut       : timer expired (level)
//     ones          : timer ones BCD digit
//     enable        : timer run enable (ARM, RUN)
//     reconfig      : one-cycle timer reload (LOAD)
//     round_active  : high in ARM and RUN
//     warn          : round_active and ones <= WARN_DIGIT (combinational)
//     score         : BCD count of correct rounds
//     lives         : remaining lives
//     win / lose    : high while in WIN / LOSE
module morse_round_ctrl
  import morse_pkg::*;
#(
  parameter int LIVES      = LIVES_DEF,
  parameter int WIN_SCORE  = WIN_SCORE_DEF,
  parameter int WARN_DIGIT = WARN_DIGIT_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       guess_valid,
  input  logic       guess_correct,
  input  logic       TimeOut,
  input  logic [3:0] ones,
  output logic       enable,
  output logic       reconfig,
  output logic       round_active,
  output logic       warn,
  output logic [3:0] score,
  output logic [1:0] lives,
  output logic       win,
  output logic       lose
);

  localparam logic [1:0] LIVES_INIT = 2'(LIVES);
  localparam bcd_t       WIN_BCD    = 4'(WIN_SCORE);
  localparam bcd_t       WARN_BCD   = 4'(WARN_DIGIT);

  state_t     r_state;
  state_t     w_next;
  logic [1:0] r_lives;
  bcd_t       w_score;
  bcd_t       w_score_nxt;
  logic       w_score_clr;
  logic       w_score_inc;
  logic       w_lives_load;
  logic       w_lives_dec;

  // Score value after this cycle's HIT increment, saturated like the counter.
  assign w_score_nxt = (w_score < MAX_BCD) ? (w_score + 4'd1) : w_score;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next       = r_state;
    w_score_clr  = 1'b0;
    w_score_inc  = 1'b0;
    w_lives_load = 1'b0;
    w_lives_dec  = 1'b0;
    case (r_state)
      ST_IDLE, ST_WIN, ST_LOSE: begin
        if (start) begin
          w_next       = ST_LOAD;
          w_score_clr  = 1'b1;
          w_lives_load = 1'b1;
        end
      end
      ST_LOAD: w_next = ST_ARM;
      // One blind cycle: the timer's registered TimeOut may still show the
      // previous round's expiry.
      ST_ARM:  w_next = ST_RUN;
      ST_RUN: begin
        // A guess outranks a simultaneous timeout.
        if (guess_valid) begin
          w_next = guess_correct ? ST_HIT : ST_MISS;
        end else if (TimeOut) begin
          w_next = ST_MISS;
        end
      end
      ST_HIT: begin
        w_score_inc = 1'b1;
        w_next      = (w_score_nxt == WIN_BCD) ? ST_WIN : ST_LOAD;
      end
      ST_MISS: begin
        w_lives_dec = 1'b1;
        w_next      = (r_lives <= 2'd1) ? ST_LOSE : ST_LOAD;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_lives <= LIVES_INIT;
    end else if (w_lives_load) begin
      r_lives <= LIVES_INIT;
    end else if (w_lives_dec && (r_lives != 2'd0)) begin
      r_lives <= r_lives - 2'd1;
    end
  end

  bcd_sat_counter u_score (
    .i_clk   (clk),
    .i_rst_n (rst),
    .i_clr   (w_score_clr),
    .i_inc   (w_score_inc),
    .o_q     (w_score)
  );

  assign round_active = (r_state == ST_ARM) || (r_state == ST_RUN);
  assign enable       = round_active;
  assign reconfig     = (r_state == ST_LOAD);
  assign win          = (r_state == ST_WIN);
  assign lose         = (r_state == ST_LOSE);
  assign warn         = round_active && (ones <= WARN_BCD);
  assign score        = w_score;
  assign lives        = r_lives;

endmodule

// File: tb/tb_morse_round_ctrl.sv
// tb_morse_round_ctrl
//   Cycle table for the main flow plus hand-written sequences for reset
//   mid-round, the full win path and the held-TimeOut lose path.
module tb_morse_round_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       guess_valid = 1'b0;
  logic       guess_correct = 1'b0;
  logic       TimeOut = 1'b0;
  logic [3:0] ones = 4'd9;
  logic       enable, reconfig, round_active, warn, win, lose;
  logic [3:0] score;
  logic [1:0] lives;

  int checks = 0;
  int failures = 0;
  int rc_cnt = 0;
  logic mon_en = 1'b0;
  logic prev_rc = 1'b0;

  always #5 clk = ~clk;

  morse_round_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .guess_valid(guess_valid),
    .guess_correct(guess_correct), .TimeOut(TimeOut), .ones(ones),
    .enable(enable), .reconfig(reconfig), .round_active(round_active),
    .warn(warn), .score(score), .lives(lives), .win(win), .lose(lose)
  );

  typedef struct {
    logic       st, gv, gc, to;
    logic [3:0] on;
    logic       en, rc, ra, wr;
    logic [3:0] sc;
    logic [1:0] lv;
    logic       wn, ls;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(logic st, logic gv, logic gc, logic to, logic [3:0] on,
                              logic en, logic rc, logic ra, logic wr,
                              logic [3:0] sc, logic [1:0] lv, logic wn, logic ls);
    vec_t v;
    v.st = st; v.gv = gv; v.gc = gc; v.to = to; v.on = on;
    v.en = en; v.rc = rc; v.ra = ra; v.wr = wr;
    v.sc = sc; v.lv = lv; v.wn = wn; v.ls = ls;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reconfig pulse counter and protocol checks, sampled on the falling edge.
  always @(negedge clk) begin
    if (mon_en) begin
      if (reconfig) rc_cnt++;
      if (reconfig && prev_rc) begin
        checks++; failures++;
        $display("FAIL reconfig_back_to_back actual=1 expected=0 at %0t", $time);
      end
      if (reconfig && enable) begin
        checks++; failures++;
        $display("FAIL enable_during_reconfig actual=1 expected=0 at %0t", $time);
      end
    end
    prev_rc = reconfig;
  end

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_enable"}, enable, 0);
    chk({tag, "_reconfig"}, reconfig, 0);
    chk({tag, "_round_active"}, round_active, 0);
    chk({tag, "_warn"}, warn, 0);
    chk({tag, "_score"}, score, 0);
    chk({tag, "_lives"}, lives, 3);
    chk({tag, "_win"}, win, 0);
    chk({tag, "_lose"}, lose, 0);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    start = 0; guess_valid = 0; guess_correct = 0; TimeOut = 0; ones = 4'd9;
    rst = 0;
    #1;
    chk_reset_outs("rst_hold");
    @(negedge clk);
    rst = 1;
  endtask

  // Wait (bounded) for the ARM cycle, then step into the first RUN cycle.
  task automatic wait_run(input string tag);
    int n = 0;
    while (!enable && n < 12) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_reach_arm"}, enable, 1);
    @(negedge clk);
  endtask

  initial begin
    // ---------------- table-driven main flow ----------------
    //            st gv gc to on  en rc ra wr sc lv wn ls
    tv.push_back(mk(0, 0, 0, 0, 9, 0, 0, 0, 0, 0, 3, 0, 0)); // IDLE
    tv.push_back(mk(0, 1, 1, 0, 9, 0, 0, 0, 0, 0, 3, 0, 0)); // IDLE guess ignored
    tv.push_back(mk(1, 0, 0, 0, 9, 0, 0, 0, 0, 0, 3, 0, 0)); // IDLE start
    tv.push_back(mk(1, 1, 1, 0, 9, 0, 1, 0, 0, 0, 3, 0, 0)); // LOAD, inputs ignored
    tv.push_back(mk(0, 0, 0, 1, 5, 1, 0, 1, 0, 0, 3, 0, 0)); // ARM, TimeOut ignored
    tv.push_back(mk(0, 0, 0, 0, 3, 1, 0, 1, 0, 0, 3, 0, 0)); // RUN ones=3
    tv.push_back(mk(1, 0, 0, 0, 2, 1, 0, 1, 1, 0, 3, 0, 0)); // RUN ones=2, start ignored
    tv.push_back(mk(0, 1, 1, 1, 2, 1, 0, 1, 1, 0, 3, 0, 0)); // RUN guess+timeout
    tv.push_back(mk(0, 0, 0, 0, 2, 0, 0, 0, 0, 0, 3, 0, 0)); // HIT
    tv.push_back(mk(0, 0, 0, 0, 9, 0, 1, 0, 0, 1, 3, 0, 0)); // LOAD score=1
    tv.push_back(mk(0, 0, 0, 0, 9, 1, 0, 1, 0, 1, 3, 0, 0)); // ARM
    tv.push_back(mk(0, 1, 0, 0, 9, 1, 0, 1, 0, 1, 3, 0, 0)); // RUN wrong guess
    tv.push_back(mk(0, 0, 0, 0, 9, 0, 0, 0, 0, 1, 3, 0, 0)); // MISS
    tv.push_back(mk(0, 0, 0, 0, 9, 0, 1, 0, 0, 1, 2, 0, 0)); // LOAD lives=2
    tv.push_back(mk(0, 0, 0, 0, 1, 1, 0, 1, 1, 1, 2, 0, 0)); // ARM warn
    tv.push_back(mk(0, 0, 0, 1, 9, 1, 0, 1, 0, 1, 2, 0, 0)); // RUN timeout
    tv.push_back(mk(0, 0, 0, 0, 9, 0, 0, 0, 0, 1, 2, 0, 0)); // MISS
    tv.push_back(mk(0, 0, 0, 0, 9, 0, 1, 0, 0, 1, 1, 0, 0)); // LOAD lives=1
    tv.push_back(mk(0, 0, 0, 0, 9, 1, 0, 1, 0, 1, 1, 0, 0)); // ARM
    tv.push_back(mk(0, 1, 0, 0, 9, 1, 0, 1, 0, 1, 1, 0, 0)); // RUN wrong guess
    tv.push_back(mk(0, 0, 0, 0, 9, 0, 0, 0, 0, 1, 1, 0, 0)); // MISS
    tv.push_back(mk(0, 0, 0, 0, 9, 0, 0, 0, 0, 1, 0, 0, 1)); // LOSE
    tv.push_back(mk(0, 1, 1, 0, 9, 0, 0, 0, 0, 1, 0, 0, 1)); // LOSE guess ignored
    tv.push_back(mk(1, 0, 0, 0, 9, 0, 0, 0, 0, 1, 0, 0, 1)); // LOSE start
    tv.push_back(mk(0, 0, 0, 0, 9, 0, 1, 0, 0, 0, 3, 0, 0)); // LOAD restart
    tv.push_back(mk(0, 0, 0, 0, 9, 1, 0, 1, 0, 0, 3, 0, 0)); // ARM
    tv.push_back(mk(0, 0, 0, 0, 9, 1, 0, 1, 0, 0, 3, 0, 0)); // RUN

    apply_reset();
    for (int i = 0; i < tv.size(); i++) begin
      @(negedge clk);
      start = tv[i].st; guess_valid = tv[i].gv; guess_correct = tv[i].gc;
      TimeOut = tv[i].to; ones = tv[i].on;
      #1;
      chk($sformatf("v%0d_enable", i), enable, tv[i].en);
      chk($sformatf("v%0d_reconfig", i), reconfig, tv[i].rc);
      chk($sformatf("v%0d_round_active", i), round_active, tv[i].ra);
      chk($sformatf("v%0d_warn", i), warn, tv[i].wr);
      chk($sformatf("v%0d_score", i), score, tv[i].sc);
      chk($sformatf("v%0d_lives", i), lives, tv[i].lv);
      chk($sformatf("v%0d_win", i), win, tv[i].wn);
      chk($sformatf("v%0d_lose", i), lose, tv[i].ls);
    end

    // ---------------- reset mid-RUN ----------------
    apply_reset();
    @(negedge clk); start = 1;
    @(negedge clk); start = 0;
    wait_run("rrun");
    ones = 4'd0;
    #1;
    chk("rrun_warn_before", warn, 1);
    #2;
    rst = 0;
    #1;
    chk_reset_outs("rrun_async");
    @(negedge clk);
    rst = 1;
    mon_en = 1; rc_cnt = 0;
    repeat (4) @(negedge clk);
    #1;
    chk("rrun_no_reconfig_after", rc_cnt, 0);
    chk("rrun_enable_after", enable, 0);
    mon_en = 0;
    ones = 4'd9;

    // ---------------- win path ----------------
    apply_reset();
    mon_en = 1; rc_cnt = 0;
    @(negedge clk); start = 1;
    @(negedge clk); start = 0;
    for (int r = 0; r < 9; r++) begin
      wait_run($sformatf("win_r%0d", r));
      repeat (3) @(negedge clk);
      guess_valid = 1; guess_correct = 1;
      @(negedge clk);
      guess_valid = 0; guess_correct = 0;
      @(negedge clk);
      #1;
      chk($sformatf("win_r%0d_score", r), score, r + 1);
      if (r < 8) chk($sformatf("win_r%0d_reconfig", r), reconfig, 1);
      else begin
        chk("win_flag", win, 1);
        chk("win_enable", enable, 0);
      end
    end
    repeat (4) @(negedge clk);
    #1;
    chk("win_reconfig_total", rc_cnt, 9);
    chk("win_hold", win, 1);
    chk("win_enable_hold", enable, 0);
    chk("win_score_hold", score, 9);
    mon_en = 0;

    // ---------------- lose path, TimeOut held high ----------------
    apply_reset();
    mon_en = 1; rc_cnt = 0;
    TimeOut = 1;
    @(negedge clk); start = 1;
    @(negedge clk); start = 0;
    begin
      logic [1:0] seen[$];
      logic [1:0] last;
      last = lives;
      for (int c = 0; c < 20; c++) begin
        @(negedge clk);
        #1;
        if (lives != last) begin
          seen.push_back(lives);
          last = lives;
        end
      end
      chk("lose_changes", seen.size(), 3);
      if (seen.size() == 3) begin
        chk("lose_lives_a", seen[0], 2);
        chk("lose_lives_b", seen[1], 1);
        chk("lose_lives_c", seen[2], 0);
      end
    end
    chk("lose_flag", lose, 1);
    chk("lose_reconfig_total", rc_cnt, 3);
    chk("lose_enable", enable, 0);
    chk("lose_score", score, 0);
    TimeOut = 0;
    mon_en = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "bench time limit");
  end

endmodule
